// File: rtl/stage_seq_pkg.sv
// Shared types and helpers for the stage sequencer.
//   seq_state_t    : sequencer FSM state (IDLE, ACTIVE, HALT)
//   idx_to_onehot  : binary stage index -> one-hot stage enable (up to MAX_STAGES)
package stage_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HALT   = 2'd2
  } seq_state_t;

  localparam int MAX_STAGES = 32;
  localparam int MAX_IDX_W  = 5;

  function automatic logic [MAX_STAGES-1:0] idx_to_onehot(input logic [MAX_IDX_W-1:0] idx);
    logic [MAX_STAGES-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/stage_skip_sel.sv
// Combinational next-stage selector.
//   cur_idx  : index of the stage that is advancing
//   skip     : per-stage skip vector (bit 0 never consulted)
//   next_idx : lowest stage above cur_idx whose skip bit is clear (0 when wrapping)
//   wrap     : no such stage exists, so the instruction ends this cycle
module stage_skip_sel #(
  parameter int NUM_STAGES = 5,
  parameter int STAGE_W    = $clog2(NUM_STAGES)
) (
  input  logic [STAGE_W-1:0]    cur_idx,
  input  logic [NUM_STAGES-1:0] skip,
  output logic [STAGE_W-1:0]    next_idx,
  output logic                  wrap
);

  // Scan downwards so the last match written is the lowest eligible stage.
  always_comb begin
    next_idx = '0;
    wrap     = 1'b1;
    for (int j = NUM_STAGES - 1; j >= 1; j--) begin
      if ((j > int'(cur_idx)) && !skip[j]) begin
        next_idx = STAGE_W'(j);
        wrap     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle stage sequencer: walks one instruction through NUM_STAGES
// one-hot stage enables on the core clock, honouring per-stage stall and skip.
//   CLK, RST     : core clock, asynchronous active-high reset
//   run          : sequence instructions (sampled only at instruction end)
//   stall, skip  : per-stage hold / bypass requests (only the current or
//                  next-candidate stage bits matter)
//   stage_en     : one-hot current stage, registered, zero outside ACTIVE
//   stage_idx    : binary current stage, registered, zero outside ACTIVE
//   retire       : combinational pulse in the cycle the last stage advances
//   busy         : state is ACTIVE
//   timeout      : state is HALT (watchdog fired; only RST leaves it)
//   retired_cnt  : wrapping count of retire pulses
//   dbg_state    : current FSM state for observation
//
// Stall semantics: a stage advances on an edge where its stall bit is low;
// while held, the consecutive-hold counter increments and the watchdog fires
// on the edge that would bring it to STALL_LIMIT.
module stage_sequencer
  import stage_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 5,
  parameter int STAGE_W     = $clog2(NUM_STAGES),
  parameter int STALL_LIMIT = 255,
  parameter int CNT_W       = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  run,
  input  logic [NUM_STAGES-1:0] stall,
  input  logic [NUM_STAGES-1:0] skip,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [STAGE_W-1:0]    stage_idx,
  output logic                  retire,
  output logic                  busy,
  output logic                  timeout,
  output logic [CNT_W-1:0]      retired_cnt,
  output seq_state_t            dbg_state
);

  // One spare bit so the counter can hold STALL_LIMIT and saturate above it.
  localparam int              SC_W     = $clog2(STALL_LIMIT + 1) + 1;
  localparam logic [SC_W-1:0] SC_LIMIT = SC_W'(STALL_LIMIT);

  seq_state_t         state_q, state_d;
  logic [STAGE_W-1:0] idx_q, idx_d;
  logic [SC_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [STAGE_W-1:0] next_idx;
  logic               wrap;
  logic               cur_stall;

  stage_skip_sel #(
    .NUM_STAGES (NUM_STAGES),
    .STAGE_W    (STAGE_W)
  ) u_skip_sel (
    .cur_idx  (idx_q),
    .skip     (skip),
    .next_idx (next_idx),
    .wrap     (wrap)
  );

  assign cur_stall = stall[idx_q];

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      stall_cnt_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      stall_cnt_q <= stall_cnt_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state logic. idx is forced to 0 whenever the next state is not
  // ACTIVE so stage_idx reads 0 in IDLE/HALT without extra gating.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    stall_cnt_d = stall_cnt_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (run) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (cur_stall) begin
          if ((STALL_LIMIT != 0) && (stall_cnt_q + SC_W'(1) == SC_LIMIT)) begin
            state_d     = HALT;
            idx_d       = '0;
            stall_cnt_d = '0;
          end else if (stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + SC_W'(1);
          end
        end else begin
          stall_cnt_d = '0;
          if (wrap) begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = '0;
            if (!run) state_d = IDLE;
          end else begin
            idx_d = next_idx;
          end
        end
      end
      HALT: begin
        idx_d       = '0;
        stall_cnt_d = '0;
      end
      default: begin
        state_d     = IDLE;
        idx_d       = '0;
        stall_cnt_d = '0;
      end
    endcase
  end

  // Output logic: everything except retire decodes flops only.
  always_comb begin
    busy      = (state_q == ACTIVE);
    timeout   = (state_q == HALT);
    retire    = busy && !cur_stall && wrap;
    stage_en  = busy ? NUM_STAGES'(idx_to_onehot(MAX_IDX_W'(idx_q))) : '0;
    stage_idx = idx_q;
  end

  assign retired_cnt = cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer (NUM_STAGES=5, STALL_LIMIT=4, CNT_W=4).
// The driver applies one cycle of inputs and queues the outputs expected in
// that cycle; the monitor pops and compares on the falling edge.
module tb_stage_sequencer;
  import stage_seq_pkg::*;

  localparam int NS = 5;
  localparam int SW = 3;
  localparam int SL = 4;
  localparam int CW = 4;
  localparam int EW = NS + SW + 3 + CW;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          run   = 1'b0;
  logic [NS-1:0] stall = '0;
  logic [NS-1:0] skip  = '0;
  logic [NS-1:0] stage_en;
  logic [SW-1:0] stage_idx;
  logic          retire, busy, timeout;
  logic [CW-1:0] retired_cnt;
  seq_state_t    dbg_state;

  stage_sequencer #(
    .NUM_STAGES  (NS),
    .STAGE_W     (SW),
    .STALL_LIMIT (SL),
    .CNT_W       (CW)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .run         (run),
    .stall       (stall),
    .skip        (skip),
    .stage_en    (stage_en),
    .stage_idx   (stage_idx),
    .retire      (retire),
    .busy        (busy),
    .timeout     (timeout),
    .retired_cnt (retired_cnt),
    .dbg_state   (dbg_state)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            errors = 0;
  int            checks = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic [EW-1:0] mon_got, mon_exp;
  string         mon_name;

  function automatic logic [SW-1:0] idx_of(input logic [NS-1:0] oh);
    logic [SW-1:0] r;
    r = '0;
    for (int k = 0; k < NS; k++) if (oh[k]) r = SW'(k);
    return r;
  endfunction

  // driver: one cycle of stimulus plus the outputs expected during it
  task automatic cyc(input logic r, input logic [NS-1:0] st, input logic [NS-1:0] sk,
                     input logic [NS-1:0] e_en, input logic e_ret, input logic e_to,
                     input string nm);
    @(posedge clk);
    #1;
    run   = r;
    stall = st;
    skip  = sk;
    exp_q.push_back({e_en, idx_of(e_en), e_ret, |e_en, e_to, exp_cnt});
    name_q.push_back(nm);
    if (e_ret) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic check_now(input string nm, input logic [EW-1:0] e, input seq_state_t e_st);
    logic [EW-1:0] g;
    g = {stage_en, stage_idx, retire, busy, timeout, retired_cnt};
    checks++;
    if (g !== e || dbg_state !== e_st) begin
      errors++;
      $display("FAIL %s got=%h state=%0d exp=%h state=%0d", nm, g, dbg_state, e, e_st);
    end
  endtask

  // Asserts reset between edges, checks the async clear, then releases.
  task automatic do_reset(input string nm);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_now(nm, '0, IDLE);
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    run     = 1'b0;
    stall   = '0;
    skip    = '0;
    exp_cnt = '0;
  endtask

  // monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_got  = {stage_en, stage_idx, retire, busy, timeout, retired_cnt};
      checks++;
      if (mon_got !== mon_exp) begin
        errors++;
        $display("FAIL %s got=%h exp=%h (en,idx,ret,busy,to,cnt)", mon_name, mon_got, mon_exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset("rst_init");

    // basic flow
    cyc(1, '0, '0, '0, 0, 0, "idle_to_run");
    for (int i = 0; i < 10; i++)
      cyc(1, '0, '0, 5'b00001 << (i % 5), (i % 5) == 4, 0, $sformatf("basic_%0d", i));

    // stall stage 3 for three cycles
    cyc(1, '0, '0, 5'b00001, 0, 0, "stall_s0");
    cyc(1, '0, '0, 5'b00010, 0, 0, "stall_s1");
    cyc(1, '0, '0, 5'b00100, 0, 0, "stall_s2");
    for (int i = 0; i < 3; i++)
      cyc(1, 5'b01000, '0, 5'b01000, 0, 0, $sformatf("stall_held_%0d", i));
    cyc(1, '0, '0, 5'b01000, 0, 0, "stall_release");
    cyc(1, '0, '0, 5'b10000, 1, 0, "stall_retire");

    // skip stage 3
    for (int rep = 0; rep < 2; rep++) begin
      cyc(1, '0, 5'b01000, 5'b00001, 0, 0, "skip3_s0");
      cyc(1, '0, 5'b01000, 5'b00010, 0, 0, "skip3_s1");
      cyc(1, '0, 5'b01000, 5'b00100, 0, 0, "skip3_s2");
      cyc(1, '0, 5'b01000, 5'b10000, 1, 0, "skip3_s4");
    end

    // everything but stage 0 skipped: retire every cycle
    for (int i = 0; i < 3; i++)
      cyc(1, '0, 5'b11110, 5'b00001, 1, 0, $sformatf("allskip_%0d", i));
    cyc(1, '0, '0, 5'b00001, 0, 0, "skip_clear");

    // run dropped in stage 2: instruction completes, then park
    cyc(1, '0, '0, 5'b00010, 0, 0, "drop_s1");
    cyc(0, '0, '0, 5'b00100, 0, 0, "drop_s2");
    cyc(0, '0, '0, 5'b01000, 0, 0, "drop_s3");
    cyc(0, '0, '0, 5'b10000, 1, 0, "drop_s4");
    cyc(0, '0, '0, '0, 0, 0, "park_idle");
    cyc(1, '0, '0, '0, 0, 0, "rerun_idle");

    // retired_cnt wrap: 9 retires so far, 7 more single-cycle instructions
    cyc(1, '0, 5'b11110, 5'b00001, 1, 0, "rerun_s0");
    for (int i = 0; i < 6; i++)
      cyc(1, '0, 5'b11110, 5'b00001, 1, 0, $sformatf("wrap_%0d", i));
    cyc(1, '0, '0, 5'b00001, 0, 0, "wrap_zero");

    // watchdog: stage 2 held for STALL_LIMIT edges
    cyc(1, '0, '0, 5'b00010, 0, 0, "wd_s1");
    for (int i = 0; i < SL; i++)
      cyc(1, 5'b00100, '0, 5'b00100, 0, 0, $sformatf("wd_held_%0d", i));
    cyc(1, 5'b00100, '0, '0, 0, 1, "wd_halt");
    cyc(0, '0, '0, '0, 0, 1, "halt_run0");
    cyc(1, '0, '0, '0, 0, 1, "halt_run1");
    cyc(0, '0, '0, '0, 0, 1, "halt_run0b");
    do_reset("rst_after_halt");

    // async reset mid-cycle while stage 3 is current
    cyc(1, '0, '0, '0, 0, 0, "ar_idle");
    for (int i = 0; i < 5; i++)
      cyc(1, '0, '0, 5'b00001 << i, i == 4, 0, $sformatf("ar_inst_%0d", i));
    cyc(1, '0, '0, 5'b00001, 0, 0, "ar_s0");
    cyc(1, '0, '0, 5'b00010, 0, 0, "ar_s1");
    cyc(1, '0, '0, 5'b00100, 0, 0, "ar_s2");
    cyc(1, 5'b01000, '0, 5'b01000, 0, 0, "ar_s3");
    do_reset("async_rst_s3");

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
